// File: rtl/scale_factor_adapt.sv
// Quantizer scale factor adaptation for the ADPCM decoder: fast/slow factor state, limited YUP to FILTE, mixed Y.
// Optional macro SFA_INIT_EN adds an INIT input for per-channel restart without a global reset.
module scale_factor_adapt (
  input  logic        CLK,
  input  logic        RESET,
`ifdef SFA_INIT_EN
  input  logic        INIT,
`endif
  input  logic        WI_VALID,
  input  logic [11:0] WI,
  input  logic [6:0]  AL,
  input  logic [18:0] YLP,
  output logic [12:0] YUP,
  output logic [18:0] YL,
  output logic [12:0] YU,
  output logic [12:0] Y,
  output logic        Y_VALID
);

  localparam logic [12:0] YU_MIN = 13'd544;
  localparam logic [12:0] YU_MAX = 13'd5120;
  localparam logic [18:0] YL_RST = 19'd34816;

  logic [12:0] yu_q;
  logic [18:0] yl_q;
  logic [6:0]  al_q;
  logic [12:0] y_q;
  logic        pend_q;
  logic        y_valid_q;

  logic [16:0] filtd_dif;
  logic [11:0] filtd_sh;
  logic [12:0] yut;

  // FILTD then LIMB; depends only on WI and the registered YU, never on YLP.
  always_comb begin
    filtd_dif = {WI, 5'b0} - {4'b0, yu_q};
    filtd_sh  = 12'(filtd_dif >> 5);
    yut       = yu_q + {filtd_dif[16], filtd_sh};
    if (yut >= YU_MAX) begin
      YUP = YU_MAX;
    end else if (yut < YU_MIN) begin
      YUP = YU_MIN;
    end else begin
      YUP = yut;
    end
  end

  logic [12:0] yl_sh;
  logic [13:0] mix_dif;
  logic [13:0] mix_difm;
  logic [20:0] mix_full;
  logic [13:0] mix_prodm;
  logic [13:0] mix_prod;
  logic [12:0] y_d;

  // MIX: magnitude/sign form so the AL weighting is applied to an unsigned difference.
  always_comb begin
    yl_sh     = yl_q[18:6];
    mix_dif   = {1'b0, yu_q} - {1'b0, yl_sh};
    mix_difm  = mix_dif[13] ? (~mix_dif + 14'd1) : mix_dif;
    mix_full  = {7'd0, mix_difm} * {14'd0, al_q};
    mix_prodm = 14'(mix_full >> 6);
    mix_prod  = mix_dif[13] ? (~mix_prodm + 14'd1) : mix_prodm;
    y_d       = 13'({1'b0, yl_sh} + mix_prod);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      yu_q      <= YU_MIN;
      yl_q      <= YL_RST;
      al_q      <= 7'd0;
      y_q       <= YU_MIN;
      pend_q    <= 1'b0;
      y_valid_q <= 1'b0;
`ifdef SFA_INIT_EN
    end else if (INIT) begin
      yu_q      <= YU_MIN;
      yl_q      <= YL_RST;
      al_q      <= 7'd0;
      y_q       <= YU_MIN;
      pend_q    <= 1'b0;
      y_valid_q <= 1'b0;
`endif
    end else begin
      if (WI_VALID) begin
        yu_q <= YUP;
        yl_q <= YLP;
        al_q <= AL;
      end
      pend_q    <= WI_VALID;
      y_valid_q <= pend_q;
      if (pend_q) begin
        y_q <= y_d;
      end
    end
  end

  assign YU      = yu_q;
  assign YL      = yl_q;
  assign Y       = y_q;
  assign Y_VALID = y_valid_q;

endmodule
